conv_mac3x3: RTL and testbench
==============================

# conv_mac3x3

Pipelined 3x3 multiply-accumulate stage directly downstream of `conv_buffer`. Consumes one packed 3x3 pixel window per cycle, with no backpressure, using the same packing `conv_buffer` drives on `out_matrix`. Computes the signed dot product with a serially loaded 3x3 kernel plus bias, then requantizes it (round, shift, clamp) to an unsigned DATA_WIDTH output pixel. The output pixel feeds the next layer's `conv_buffer` or the pooling stage.

## Interface
Parameters:
- `DATA_WIDTH`, 8: unsigned pixel width (input and output).
- `WEIGHT_WIDTH`, 8: signed two's-complement weight width.
- `KERNEL_ROW_SIZE`, 3: fixed at 3; any other value is a parameter-check error.
- `KERNEL_COLUMN_SIZE`, 3: fixed at 3; any other value is a parameter-check error.
- `ACC_WIDTH`, DATA_WIDTH+WEIGHT_WIDTH+5: signed accumulator width.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `window_in`  in  9*DATA_WIDTH  element k = r*3+c at bits [k*DATA_WIDTH +: DATA_WIDTH]; k = 0 is the oldest row, oldest column.
- `valid_in`  in  1  window qualifier.
- `weight_in`  in  WEIGHT_WIDTH  kernel coefficient, loaded in order k = 0..8.
- `weight_valid`  in  1  weight qualifier.
- `bias_in`  in  ACC_WIDTH  signed bias; sampled together with the 9th weight.
- `shift_amt`  in  5  requantization right shift, 0..ACC_WIDTH-1; quasi-static.
- `out_pixel`  out  DATA_WIDTH  clamped result.
- `acc_out`  out  ACC_WIDTH  raw signed sum (products plus bias), before requantization.
- `valid_out`  out  1  qualifies `out_pixel` and `acc_out`.
- `weights_ready`  out  1  all 9 weights loaded.
- `drop_err`  out  1  sticky; set when `valid_in` is high while `weights_ready` is 0.

## Operation
- **Reset:**
  - All outputs 0.
  - Weight registers and bias 0.
  - `load_cnt` 0.
  - Load FSM in EMPTY.
- **Load FSM states:** EMPTY, LOADING, READY.
  - EMPTY → LOADING on `weight_valid`.
  - LOADING → READY on the 9th `weight_valid`, i.e. when `load_cnt` = 8. `bias_in` is latched on that same edge.
  - READY → LOADING on any `weight_valid`. This is a reload: `load_cnt` restarts at 0 and `weights_ready` drops on the next edge.
  - `weights_ready` = (state == READY), registered.
  - `weight_valid` low in LOADING: hold state, no timeout.
- **Window acceptance:** a window is accepted when `valid_in` && `weights_ready`.
  - Otherwise the window is discarded and `drop_err` is set. `drop_err` clears only on reset.
- **Arithmetic:**
  - Each pixel is zero-extended, then multiplied by a signed weight. Product width is DATA_WIDTH+WEIGHT_WIDTH+1.
  - Sums are sign-extended to ACC_WIDTH; no overflow is possible at the defaults.
- **Requantization:**
  - If `shift_amt` > 0, add 1<<(`shift_amt`-1) before the arithmetic right shift.
  - Clamp the result to [0, 2^DATA_WIDTH-1]. A negative result gives 0, which acts as an implicit ReLU.
- **Zero-padded edge windows** from `conv_buffer` need no special case.

## Timing
- Throughput is one window per cycle; there is no stall input.
- **Pipeline stages:**
  - S1: 9 product registers.
  - S2: 3 row-sum registers.
  - S3: total plus bias, registered into `acc` (drives `acc_out`).
  - S4: round, shift and clamp, registered into `out_pixel`.
- **Latency:** a window accepted at edge N gives `valid_out` = 1 with data after edge N+3, i.e. 4 edges.
- `acc_out` is delayed by one stage to align with `out_pixel`.
- `valid_out` is a 4-deep shift of the accept signal. Gaps in `valid_in` are preserved exactly.
- **Reload overlap:**
  - Weights are used only at S1 capture, so windows already in S1–S4 complete with the old kernel.
  - A window arriving on the same edge as the first reload weight is accepted with the old weights.
- Reset mid-stream clears all pipeline valids immediately; no stale `valid_out` appears after `rst_n` rises.
- `shift_amt` is sampled at S4. Changing it while valid data is in flight is undefined.

## Structure
- A shared package `cnn_pkg` holds:
  - the kernel-size constants (3, 3, 9);
  - an `ACC_WIDTH` helper function;
  - the load-FSM state encoding.
- Sub-module `requant_clamp`: combinational round, shift and clamp, instantiated once before the S4 register.
- The multiply array and adder tree stay inline.

## Test plan
- Load 9 weights of 1, bias 0, shift 0; window of all 10 → 4 edges later `acc_out` = 90, `out_pixel` = 90, `valid_out` high for 1 cycle.
- Same stimulus with weights all −1 → `acc_out` = −90, `out_pixel` = 0.
- Weights all 127, window all 255, bias 1000 → `acc_out` = 292465, `out_pixel` = 255 (saturated).
- Weights 1, shift 2, window all 10 → (90+2)>>2 gives `out_pixel` = 23. Shift 3 with acc 84 → 11 (round-half-up).
- Back-to-back windows 1, 2, 3 with a gap, then a reload to weights 2 starting on the same edge as window 4 → windows 1–4 produce 9, 18, 27, 36 with the gap preserved. Windows sent during LOADING are dropped and `drop_err` = 1. After READY, window 5 produces 90.
- Assert `rst_n` low while 3 windows are in flight → `valid_out`, `weights_ready`, `drop_err` and `out_pixel` are 0 immediately and stay 0 after release until reload.

Source files
------------

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared kernel constants, accumulator sizing and load-FSM encoding
package cnn_pkg;

    localparam int KERNEL_ROWS = 3;
    localparam int KERNEL_COLS = 3;
    localparam int KERNEL_TAPS = 9;

    function automatic int acc_width(input int data_width, input int weight_width);
        return data_width + weight_width + 5;
    endfunction

    typedef enum logic [1:0] {
        LOAD_EMPTY   = 2'd0,
        LOAD_LOADING = 2'd1,
        LOAD_READY   = 2'd2
    } load_state_t;

endpackage

// File: rtl/requant_clamp.sv
// rtl/requant_clamp.sv - round-half-up, arithmetic right shift and clamp to an unsigned pixel
module requant_clamp #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 21
) (
    input  logic [ACC_WIDTH-1:0]  i_acc,
    input  logic [4:0]            i_shift,
    output logic [DATA_WIDTH-1:0] o_pixel
);
    localparam int EXT_W = ACC_WIDTH + 1;
    localparam logic signed [EXT_W-1:0] MAX_PIX = EXT_W'((64'd1 << DATA_WIDTH) - 64'd1);

    logic signed [EXT_W-1:0] w_round;
    logic signed [EXT_W-1:0] w_sum;
    logic signed [EXT_W-1:0] w_shifted;

    // One extra bit keeps the rounding add from overflowing near the accumulator limit.
    always_comb begin
        w_round = '0;
        if (i_shift != 5'd0) begin
            w_round = {{(EXT_W-1){1'b0}}, 1'b1} << (i_shift - 5'd1);
        end
        w_sum     = {i_acc[ACC_WIDTH-1], i_acc} + w_round;
        w_shifted = w_sum >>> i_shift;
        if (w_shifted[EXT_W-1]) begin
            o_pixel = '0;
        end else if (w_shifted > MAX_PIX) begin
            o_pixel = '1;
        end else begin
            o_pixel = w_shifted[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/conv_mac3x3.sv
// rtl/conv_mac3x3.sv - pipelined 3x3 signed MAC with serial kernel load and requantized output
module conv_mac3x3
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int WEIGHT_WIDTH       = 8,
    parameter int KERNEL_ROW_SIZE    = 3,
    parameter int KERNEL_COLUMN_SIZE = 3,
    parameter int ACC_WIDTH          = acc_width(DATA_WIDTH, WEIGHT_WIDTH)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [KERNEL_TAPS*DATA_WIDTH-1:0] window_in,
    input  logic                              valid_in,
    input  logic [WEIGHT_WIDTH-1:0]           weight_in,
    input  logic                              weight_valid,
    input  logic [ACC_WIDTH-1:0]              bias_in,
    input  logic [4:0]                        shift_amt,
    output logic [DATA_WIDTH-1:0]             out_pixel,
    output logic [ACC_WIDTH-1:0]              acc_out,
    output logic                              valid_out,
    output logic                              weights_ready,
    output logic                              drop_err
);
    localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH + 1;

    generate
        if (KERNEL_ROW_SIZE != KERNEL_ROWS || KERNEL_COLUMN_SIZE != KERNEL_COLS) begin : g_param_check
            $error("conv_mac3x3 supports only a 3x3 kernel");
        end
    endgenerate

    load_state_t r_state, w_next_state;
    logic [3:0]  r_load_cnt, w_next_cnt, w_load_idx;
    logic        r_weights_ready, r_drop_err, w_accept;
    logic [3:0]  r_valid_pipe;

    logic signed [WEIGHT_WIDTH-1:0] r_weight  [KERNEL_TAPS];
    logic signed [ACC_WIDTH-1:0]    r_bias;
    logic signed [PROD_W-1:0]       r_prod    [KERNEL_TAPS];
    logic signed [PROD_W-1:0]       w_prod    [KERNEL_TAPS];
    logic signed [ACC_WIDTH-1:0]    r_row_sum [KERNEL_ROWS];
    logic signed [ACC_WIDTH-1:0]    w_row_sum [KERNEL_ROWS];
    logic signed [ACC_WIDTH-1:0]    w_total, r_acc, r_acc_out;
    logic [DATA_WIDTH-1:0]          r_out_pixel, w_requant;

    function automatic logic signed [ACC_WIDTH-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
        return {{(ACC_WIDTH-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    // The first weight of every load (initial or reload) lands in tap 0.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_load_cnt;
        w_load_idx   = 4'd0;
        case (r_state)
            LOAD_EMPTY, LOAD_READY: begin
                if (weight_valid) begin
                    w_next_state = LOAD_LOADING;
                    w_next_cnt   = 4'd1;
                end
            end
            LOAD_LOADING: begin
                w_load_idx = r_load_cnt;
                if (weight_valid) begin
                    if (r_load_cnt == 4'd8) begin
                        w_next_state = LOAD_READY;
                        w_next_cnt   = 4'd0;
                    end else begin
                        w_next_cnt = r_load_cnt + 4'd1;
                    end
                end
            end
            default: begin
                w_next_state = LOAD_EMPTY;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= LOAD_EMPTY;
            r_load_cnt      <= 4'd0;
            r_weights_ready <= 1'b0;
            r_bias          <= '0;
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                r_weight[k] <= '0;
            end
        end else begin
            r_state         <= w_next_state;
            r_load_cnt      <= w_next_cnt;
            r_weights_ready <= (w_next_state == LOAD_READY);
            if (weight_valid) begin
                r_weight[w_load_idx] <= weight_in;
                if (r_state == LOAD_LOADING && r_load_cnt == 4'd8) begin
                    r_bias <= bias_in;
                end
            end
        end
    end

    assign w_accept = valid_in && r_weights_ready;

    always_comb begin
        for (int k = 0; k < KERNEL_TAPS; k++) begin
            w_prod[k] = $signed({{(WEIGHT_WIDTH+1){1'b0}}, window_in[k*DATA_WIDTH +: DATA_WIDTH]})
                      * $signed({{(DATA_WIDTH+1){r_weight[k][WEIGHT_WIDTH-1]}}, r_weight[k]});
        end
        for (int r = 0; r < KERNEL_ROWS; r++) begin
            w_row_sum[r] = sext_prod(r_prod[r*3]) + sext_prod(r_prod[r*3+1]) + sext_prod(r_prod[r*3+2]);
        end
        w_total = r_row_sum[0] + r_row_sum[1] + r_row_sum[2] + r_bias;
    end

    requant_clamp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_requant (
        .i_acc   (r_acc),
        .i_shift (shift_amt),
        .o_pixel (w_requant)
    );

    // Stage registers only load when their stage holds a valid window, so idle data stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_pipe <= 4'd0;
            r_drop_err   <= 1'b0;
            r_acc        <= '0;
            r_acc_out    <= '0;
            r_out_pixel  <= '0;
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                r_prod[k] <= '0;
            end
            for (int r = 0; r < KERNEL_ROWS; r++) begin
                r_row_sum[r] <= '0;
            end
        end else begin
            r_valid_pipe <= {r_valid_pipe[2:0], w_accept};
            if (valid_in && !r_weights_ready) begin
                r_drop_err <= 1'b1;
            end
            if (w_accept) begin
                for (int k = 0; k < KERNEL_TAPS; k++) begin
                    r_prod[k] <= w_prod[k];
                end
            end
            if (r_valid_pipe[0]) begin
                for (int r = 0; r < KERNEL_ROWS; r++) begin
                    r_row_sum[r] <= w_row_sum[r];
                end
            end
            if (r_valid_pipe[1]) begin
                r_acc <= w_total;
            end
            if (r_valid_pipe[2]) begin
                r_acc_out   <= r_acc;
                r_out_pixel <= w_requant;
            end
        end
    end

    assign out_pixel     = r_out_pixel;
    assign acc_out       = r_acc_out;
    assign valid_out     = r_valid_pipe[3];
    assign weights_ready = r_weights_ready;
    assign drop_err      = r_drop_err;

endmodule

// File: tb/tb_conv_mac3x3.sv
// tb/tb_conv_mac3x3.sv - self-checking bench for conv_mac3x3
module tb_conv_mac3x3;
    localparam int DW = 8;
    localparam int WW = 8;
    localparam int AW = 21;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [9*DW-1:0] window_in;
    logic          valid_in;
    logic [WW-1:0] weight_in;
    logic          weight_valid;
    logic [AW-1:0] bias_in;
    logic [4:0]    shift_amt;
    logic [DW-1:0] out_pixel;
    logic [AW-1:0] acc_out;
    logic          valid_out;
    logic          weights_ready;
    logic          drop_err;

    always #5 clk = ~clk;

    conv_mac3x3 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .window_in     (window_in),
        .valid_in      (valid_in),
        .weight_in     (weight_in),
        .weight_valid  (weight_valid),
        .bias_in       (bias_in),
        .shift_amt     (shift_amt),
        .out_pixel     (out_pixel),
        .acc_out       (acc_out),
        .valid_out     (valid_out),
        .weights_ready (weights_ready),
        .drop_err      (drop_err)
    );

    typedef struct {
        int     w;
        int     p;
        int     b;
        int     s;
        longint e_acc;
        int     e_pix;
    } vec_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     edge_n   = 0;
    int     pix [9];
    longint m_w [9];
    longint m_bias;
    bit     m_ready, m_loading, m_drop;
    int     m_cnt;
    longint exp_acc [int];
    longint exp_pix [int];
    longint got_q [$];

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic longint requant(input longint a, input int s);
        longint r;
        r = a + ((s > 0) ? (longint'(1) << (s - 1)) : longint'(0));
        r = r >>> s;
        if (r < 0) return 0;
        if (r > 255) return 255;
        return r;
    endfunction

    task automatic drive_window(input bit v);
        valid_in = v;
        for (int k = 0; k < 9; k++) begin
            window_in[k*DW +: DW] = DW'(pix[k]);
        end
    endtask

    task automatic model_clear();
        m_ready   = 0;
        m_loading = 0;
        m_drop    = 0;
        m_bias    = 0;
        m_cnt     = 0;
        for (int k = 0; k < 9; k++) m_w[k] = 0;
        exp_acc.delete();
        exp_pix.delete();
    endtask

    // Advance one clock: update the reference model from the inputs about to be
    // sampled, then check every output shortly after the edge.
    task automatic tick();
        longint a;
        if (rst_n) begin
            if (valid_in && m_ready) begin
                a = m_bias;
                for (int k = 0; k < 9; k++) a += longint'(pix[k]) * m_w[k];
                exp_acc[edge_n + 4] = a;
                exp_pix[edge_n + 4] = requant(a, int'(shift_amt));
            end
            if (valid_in && !m_ready) m_drop = 1;
            if (weight_valid) begin
                if (!m_loading) begin
                    m_loading = 1;
                    m_cnt     = 0;
                    m_ready   = 0;
                end
                m_w[m_cnt] = longint'($signed(weight_in));
                m_cnt++;
                if (m_cnt == 9) begin
                    m_bias    = longint'($signed(bias_in));
                    m_loading = 0;
                    m_ready   = 1;
                end
            end
        end
        @(posedge clk);
        edge_n++;
        #1;
        chk("valid_out", longint'(valid_out), longint'(exp_acc.exists(edge_n)));
        if (valid_out) got_q.push_back(longint'($signed(acc_out)));
        if (exp_acc.exists(edge_n)) begin
            chk("acc_out", longint'($signed(acc_out)), exp_acc[edge_n]);
            chk("out_pixel", longint'(out_pixel), exp_pix[edge_n]);
            exp_acc.delete(edge_n);
            exp_pix.delete(edge_n);
        end
        chk("weights_ready", longint'(weights_ready), longint'(m_ready));
        chk("drop_err", longint'(drop_err), longint'(m_drop));
    endtask

    task automatic load_weights(input int wv [9], input int b, input bit busy);
        for (int k = 0; k < 9; k++) begin
            weight_valid = 1'b1;
            weight_in    = WW'(wv[k]);
            bias_in      = AW'(b);
            if (busy) begin
                for (int j = 0; j < 9; j++) pix[j] = int'($urandom_range(0, 255));
                drive_window($urandom_range(0, 1) == 1);
            end
            tick();
        end
        weight_valid = 1'b0;
        drive_window(1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid_out"}, longint'(valid_out), 0);
        chk({tag, "_weights_ready"}, longint'(weights_ready), 0);
        chk({tag, "_drop_err"}, longint'(drop_err), 0);
        chk({tag, "_out_pixel"}, longint'(out_pixel), 0);
        chk({tag, "_acc_out"}, longint'(acc_out), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [11];
        int   wv [9];
        longint exp_seq [5];

        vecs[0]  = '{1,    10,  0,    0, 90,      90};
        vecs[1]  = '{-1,   10,  0,    0, -90,     0};
        vecs[2]  = '{127,  255, 1000, 0, 292465,  255};
        vecs[3]  = '{1,    10,  0,    2, 90,      23};
        vecs[4]  = '{1,    9,   3,    3, 84,      11};
        vecs[5]  = '{-128, 255, 0,    0, -293760, 0};
        vecs[6]  = '{2,    7,   -1,   1, 125,     63};
        vecs[7]  = '{1,    28,  3,    0, 255,     255};
        vecs[8]  = '{1,    28,  4,    0, 256,     255};
        vecs[9]  = '{-3,   200, 5500, 4, 100,     6};
        vecs[10] = '{-1,   3,   20,   2, -7,      0};

        rst_n = 1'b0;
        valid_in = 1'b0; weight_valid = 1'b0; weight_in = '0; bias_in = '0;
        shift_amt = '0; window_in = '0;
        for (int k = 0; k < 9; k++) pix[k] = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Table-driven single windows with a uniform kernel.
        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < 9; k++) wv[k] = vecs[i].w;
            shift_amt = 5'(vecs[i].s);
            load_weights(wv, vecs[i].b, 1'b0);
            for (int k = 0; k < 9; k++) pix[k] = vecs[i].p;
            drive_window(1'b1);
            tick();
            drive_window(1'b0);
            repeat (3) tick();
            chk("tbl_valid", longint'(valid_out), 1);
            chk("tbl_acc", longint'($signed(acc_out)), vecs[i].e_acc);
            chk("tbl_pix", longint'(out_pixel), longint'(vecs[i].e_pix));
            tick();
            chk("tbl_single_pulse", longint'(valid_out), 0);
            tick();
        end

        // Streaming with a gap, then a reload starting on the same edge as window 4.
        for (int k = 0; k < 9; k++) wv[k] = 1;
        shift_amt = 5'd0;
        load_weights(wv, 0, 1'b0);
        repeat (4) tick();
        got_q.delete();
        for (int w = 1; w <= 3; w++) begin
            for (int k = 0; k < 9; k++) pix[k] = w;
            drive_window(1'b1);
            tick();
        end
        drive_window(1'b0);
        tick();
        for (int k = 0; k < 9; k++) pix[k] = 4;
        drive_window(1'b1);
        weight_valid = 1'b1; weight_in = WW'(2); bias_in = '0;
        tick();
        for (int k = 0; k < 9; k++) pix[k] = 7;
        drive_window(1'b1);
        repeat (8) tick();
        weight_valid = 1'b0;
        drive_window(1'b0);
        tick();
        for (int k = 0; k < 9; k++) pix[k] = 5;
        drive_window(1'b1);
        tick();
        drive_window(1'b0);
        repeat (5) tick();
        exp_seq = '{9, 18, 27, 36, 90};
        chk("seq_count", longint'(got_q.size()), 5);
        for (int i = 0; i < 5; i++) begin
            chk("seq_acc", (i < got_q.size()) ? got_q[i] : -1, exp_seq[i]);
        end
        chk("seq_drop_err", longint'(drop_err), 1);

        // Randomized blocks: reload under traffic, then random streaming.
        for (int blk = 0; blk < 4; blk++) begin
            shift_amt = 5'($urandom_range(0, 10));
            for (int k = 0; k < 9; k++) wv[k] = int'($urandom_range(0, 255));
            load_weights(wv, int'($urandom_range(0, 8000)) - 4000, 1'b1);
            for (int c = 0; c < 150; c++) begin
                for (int k = 0; k < 9; k++) pix[k] = int'($urandom_range(0, 255));
                drive_window($urandom_range(0, 3) != 0);
                tick();
            end
            drive_window(1'b0);
            repeat (5) tick();
        end

        // Reset with three windows in flight.
        for (int k = 0; k < 9; k++) pix[k] = 10;
        repeat (3) begin
            drive_window(1'b1);
            tick();
        end
        drive_window(1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_clear();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check_reset_outputs("post_rst");

        chk("pending_outputs", longint'(exp_acc.num()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
